// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multi-cycle control unit.
//   - state_e        : 4-bit controller state encoding
//   - SRCB_* / PC_*  : ALUSrcB and PCSource selector values
//   - ALUOp_*        : 5-bit ALU operation codes
//   - OP_* / FN_*    : instruction opcode and R-type funct fields
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RTWB   = 4'd7,
        S_IEXEC  = 4'd8,
        S_IWB    = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

    // ALU B-operand select
    localparam logic [1:0] SRCB_RT      = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'd3;

    // PC source select
    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    // ALU operation codes
    localparam logic [4:0] ALUOp_NOP  = 5'd0;
    localparam logic [4:0] ALUOp_ADD  = 5'd1;
    localparam logic [4:0] ALUOp_SUB  = 5'd2;
    localparam logic [4:0] ALUOp_ADDU = 5'd3;
    localparam logic [4:0] ALUOp_SUBU = 5'd4;
    localparam logic [4:0] ALUOp_AND  = 5'd5;
    localparam logic [4:0] ALUOp_OR   = 5'd6;
    localparam logic [4:0] ALUOp_SLT  = 5'd7;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

endpackage

// File: rtl/mc_ctrl_alu_dec.sv
// alu_dec: combinational R-type Funct -> ALUOp map.
//   i_funct   : instruction[5:0]
//   o_aluop   : ALU operation for the funct (NOP when unknown)
//   o_illegal : funct is not a supported R-type operation
module alu_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [4:0] o_aluop,
    output logic       o_illegal
);

    always_comb begin
        o_aluop   = ALUOp_NOP;
        o_illegal = 1'b0;
        case (i_funct)
            FN_ADD:  o_aluop = ALUOp_ADD;
            FN_ADDU: o_aluop = ALUOp_ADDU;
            FN_SUB:  o_aluop = ALUOp_SUB;
            FN_SUBU: o_aluop = ALUOp_SUBU;
            FN_AND:  o_aluop = ALUOp_AND;
            FN_OR:   o_aluop = ALUOp_OR;
            FN_SLT:  o_aluop = ALUOp_SLT;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle CPU control unit. Sequences each instruction through
// FETCH/DECODE/execute/memory/writeback states and drives datapath enables.
//   clk, rst           : clock, synchronous active-high reset
//   Op, Funct          : instruction[31:26], instruction[5:0]
//   Zero               : ALU equality flag, used only in BRANCH
//   MemReady           : memory completes the current access this cycle
//   PCWrite..PCSource  : datapath enables and mux selects
//   ALUOp              : ALU operation code
//   Illegal            : one-cycle pulse in DECODE on an undecodable instruction
//   InstrCount         : retired instruction count (wraps)
//   o_dbg_state        : current FSM state
//
// Memory handshake: the controller holds MemRead/MemWrite and the address
// select stable while waiting; an access completes in the cycle MemReady is
// high, and only then does the state advance (and IR/PC load in FETCH).
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  Op,
    input  logic [5:0]  Funct,
    input  logic        Zero,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        RegDst,
    output logic        MemtoReg,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic        EXTOp,
    output logic [1:0]  PCSource,
    output logic [4:0]  ALUOp,
    output logic        Illegal,
    output logic [31:0] InstrCount,
    output state_e      o_dbg_state
);

    state_e      r_state;
    state_e      w_next_state;
    logic [31:0] r_instr_count;
    logic [4:0]  w_dec_aluop;
    logic        w_dec_illegal;
    logic        w_retire;
    logic        w_pc_write, w_ir_write, w_mem_read, w_mem_write;
    logic        w_reg_write, w_illegal;

    alu_dec u_alu_dec (
        .i_funct   (Funct),
        .o_aluop   (w_dec_aluop),
        .o_illegal (w_dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_FETCH;
            r_instr_count <= 32'd0;
        end else begin
            r_state <= w_next_state;
            if (w_retire)
                r_instr_count <= r_instr_count + 32'd1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_retire     = 1'b0;
        w_pc_write   = 1'b0;
        w_ir_write   = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_illegal    = 1'b0;
        IorD         = 1'b0;
        RegDst       = 1'b0;
        MemtoReg     = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = SRCB_RT;
        EXTOp        = 1'b0;
        PCSource     = PC_ALU;
        ALUOp        = ALUOp_NOP;
        case (r_state)
            S_FETCH: begin
                w_mem_read = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ALUOp      = ALUOp_ADDU;
                if (MemReady) begin
                    w_ir_write   = 1'b1;
                    w_pc_write   = 1'b1;
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target PC+4 + (imm << 2) is computed here speculatively.
                ALUSrcB = SRCB_IMM_SL2;
                EXTOp   = 1'b1;
                ALUOp   = ALUOp_ADDU;
                case (Op)
                    OP_LW, OP_SW:   w_next_state = S_MEMADR;
                    OP_ADDI, OP_ORI: w_next_state = S_IEXEC;
                    OP_BEQ:         w_next_state = S_BRANCH;
                    OP_J:           w_next_state = S_JUMP;
                    OP_RTYPE: begin
                        if (w_dec_illegal) begin
                            w_illegal    = 1'b1;
                            w_next_state = S_FETCH;
                        end else begin
                            w_next_state = S_EXEC;
                        end
                    end
                    default: begin
                        w_illegal    = 1'b1;
                        w_next_state = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = SRCB_IMM;
                EXTOp        = 1'b1;
                ALUOp        = ALUOp_ADDU;
                w_next_state = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                IorD       = 1'b1;
                w_mem_read = 1'b1;
                if (MemReady)
                    w_next_state = S_MEMWB;
            end
            S_MEMWB: begin
                w_reg_write  = 1'b1;
                MemtoReg     = 1'b1;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWR: begin
                IorD        = 1'b1;
                w_mem_write = 1'b1;
                if (MemReady) begin
                    w_retire     = 1'b1;
                    w_next_state = S_FETCH;
                end
            end
            S_EXEC: begin
                ALUSrcA      = 1'b1;
                ALUOp        = w_dec_aluop;
                w_next_state = S_RTWB;
            end
            S_RTWB: begin
                w_reg_write  = 1'b1;
                RegDst       = 1'b1;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                if (Op == OP_ORI) begin
                    EXTOp = 1'b0;
                    ALUOp = ALUOp_OR;
                end else begin
                    EXTOp = 1'b1;
                    ALUOp = ALUOp_ADD;
                end
                w_next_state = S_IWB;
            end
            S_IWB: begin
                w_reg_write  = 1'b1;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA      = 1'b1;
                ALUOp        = ALUOp_SUB;
                PCSource     = PC_ALUOUT;
                w_pc_write   = Zero;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_JUMP: begin
                PCSource     = PC_JUMP;
                w_pc_write   = 1'b1;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end
            default: w_next_state = S_FETCH;
        endcase
    end

    // Side-effecting strobes are suppressed during reset so an abandoned
    // instruction cannot write the PC, IR, memory or register file.
    assign PCWrite  = w_pc_write  & ~rst;
    assign IRWrite  = w_ir_write  & ~rst;
    assign MemRead  = w_mem_read  & ~rst;
    assign MemWrite = w_mem_write & ~rst;
    assign RegWrite = w_reg_write & ~rst;
    assign Illegal  = w_illegal   & ~rst;

    assign InstrCount  = r_instr_count;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mc_ctrl.sv
module tb_mc_ctrl;
    import mc_ctrl_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [5:0]  Op, Funct;
    logic        Zero, MemReady;
    logic        PCWrite, IRWrite, IorD, MemRead, MemWrite;
    logic        RegWrite, RegDst, MemtoReg, ALUSrcA;
    logic [1:0]  ALUSrcB, PCSource;
    logic        EXTOp, Illegal;
    logic [4:0]  ALUOp;
    logic [31:0] InstrCount;
    state_e      dbg_state;

    mc_ctrl dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
        .MemReady(MemReady), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .EXTOp(EXTOp),
        .PCSource(PCSource), .ALUOp(ALUOp), .Illegal(Illegal),
        .InstrCount(InstrCount), .o_dbg_state(dbg_state)
    );

    typedef struct packed {
        logic [3:0]  st;
        logic        pcw, irw, iord, mrd, mwr, rgw, rdst, m2r, srca;
        logic [1:0]  srcb;
        logic        ext;
        logic [1:0]  pcs;
        logic [4:0]  aluop;
        logic        ill;
        logic [31:0] cnt;
    } obs_t;
    localparam int W = $bits(obs_t);

    obs_t act;
    assign act = {dbg_state, PCWrite, IRWrite, IorD, MemRead, MemWrite,
                  RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, EXTOp,
                  PCSource, ALUOp, Illegal, InstrCount};

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           errors = 0;
    int           checks = 0;
    logic [31:0]  exp_cnt = 32'd0;

    function automatic logic [4:0] ref_rop(input logic [5:0] f);
        case (f)
            6'h20: return ALUOp_ADD;
            6'h21: return ALUOp_ADDU;
            6'h22: return ALUOp_SUB;
            6'h23: return ALUOp_SUBU;
            6'h24: return ALUOp_AND;
            6'h25: return ALUOp_OR;
            6'h2A: return ALUOp_SLT;
            default: return ALUOp_NOP;
        endcase
    endfunction

    function automatic logic ref_illegal(input logic [5:0] op, input logic [5:0] f);
        case (op)
            6'h23, 6'h2B, 6'h04, 6'h08, 6'h0D, 6'h02: return 1'b0;
            6'h00: return (ref_rop(f) == ALUOp_NOP);
            default: return 1'b1;
        endcase
    endfunction

    // Expected outputs for a given state and inputs, read off the state table.
    function automatic obs_t model(input state_e s, input logic mr, input logic z,
                                   input logic r, input logic [5:0] op,
                                   input logic [5:0] f, input logic [31:0] cnt);
        obs_t e;
        e     = '0;
        e.st  = s;
        e.cnt = cnt;
        case (s)
            S_FETCH:  begin e.mrd = 1; e.srcb = 2'd1; e.aluop = ALUOp_ADDU; e.irw = mr; e.pcw = mr; end
            S_DECODE: begin e.srcb = 2'd3; e.ext = 1; e.aluop = ALUOp_ADDU; e.ill = ref_illegal(op, f); end
            S_MEMADR: begin e.srca = 1; e.srcb = 2'd2; e.ext = 1; e.aluop = ALUOp_ADDU; end
            S_MEMRD:  begin e.iord = 1; e.mrd = 1; end
            S_MEMWB:  begin e.rgw = 1; e.m2r = 1; end
            S_MEMWR:  begin e.iord = 1; e.mwr = 1; end
            S_EXEC:   begin e.srca = 1; e.srcb = 2'd0; e.aluop = ref_rop(f); end
            S_RTWB:   begin e.rgw = 1; e.rdst = 1; end
            S_IEXEC:  begin
                e.srca = 1; e.srcb = 2'd2;
                e.ext = (op == 6'h08);
                e.aluop = (op == 6'h08) ? ALUOp_ADD : ALUOp_OR;
            end
            S_IWB:    begin e.rgw = 1; end
            S_BRANCH: begin e.srca = 1; e.aluop = ALUOp_SUB; e.pcs = 2'd1; e.pcw = z; end
            S_JUMP:   begin e.pcs = 2'd2; e.pcw = 1; end
            default:  ;
        endcase
        if (r) begin
            e.pcw = 0; e.irw = 0; e.mwr = 0; e.rgw = 0; e.mrd = 0; e.ill = 0;
        end
        return e;
    endfunction

    // ---------------- driver ----------------
    // Called just after a rising edge: drive inputs, push the expectation,
    // compare on the falling edge, advance to just past the next rising edge.
    task automatic cyc(input string tag, input state_e s, input logic mr,
                       input logic z, input logic r, input bit retire);
        logic [W-1:0] e;
        MemReady = mr;
        Zero     = z;
        rst      = r;
        exp_q.push_back(model(s, mr, z, r, Op, Funct, exp_cnt));
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        assert (act === e) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, act, e);
        end
        @(posedge clk);
        #1;
        if (r) exp_cnt = 32'd0;
        else if (retire) exp_cnt = exp_cnt + 32'd1;
    endtask

    task automatic fetch_decode(input string tag, input logic [5:0] op, input logic [5:0] f);
        Op    = op;
        Funct = f;
        cyc({tag, ".fetch"}, S_FETCH, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc({tag, ".decode"}, S_DECODE, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_rtype(input string tag, input logic [5:0] f);
        fetch_decode(tag, 6'h00, f);
        cyc({tag, ".exec"}, S_EXEC, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc({tag, ".rtwb"}, S_RTWB, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    logic [5:0] rfuncts [6];

    initial begin
        rst      = 1'b1;
        Op       = 6'h00;
        Funct    = 6'h00;
        Zero     = 1'b0;
        MemReady = 1'b1;
        @(posedge clk);
        #1;
        cyc("reset", S_FETCH, 1'b1, 1'b0, 1'b1, 1'b0);

        // subu: 4 cycles, one retire
        run_rtype("subu", 6'h23);
        checks++;
        assert (InstrCount === 32'd1) else begin
            errors++;
            $error("FAIL subu_count: got %0d expected 1", InstrCount);
        end

        // lw with MemReady low two cycles in MEMRD: 7 cycles
        fetch_decode("lw", 6'h23, 6'h00);
        cyc("lw.memadr", S_MEMADR, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("lw.memrd0", S_MEMRD, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("lw.memrd1", S_MEMRD, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("lw.memrd2", S_MEMRD, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("lw.memwb", S_MEMWB, 1'b1, 1'b0, 1'b0, 1'b1);

        // beq taken / not taken / Zero only in DECODE
        fetch_decode("beq1", 6'h04, 6'h00);
        cyc("beq1.branch", S_BRANCH, 1'b1, 1'b1, 1'b0, 1'b1);
        fetch_decode("beq0", 6'h04, 6'h00);
        cyc("beq0.branch", S_BRANCH, 1'b1, 1'b0, 1'b0, 1'b1);
        Op = 6'h04;
        cyc("beqz.fetch", S_FETCH, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("beqz.decode", S_DECODE, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("beqz.branch", S_BRANCH, 1'b1, 1'b0, 1'b0, 1'b1);

        // fetch stall then addi, ori, j
        Op = 6'h08;
        cyc("stall.fetch", S_FETCH, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("addi.fetch", S_FETCH, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("addi.decode", S_DECODE, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("addi.iexec", S_IEXEC, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("addi.iwb", S_IWB, 1'b1, 1'b0, 1'b0, 1'b1);
        fetch_decode("ori", 6'h0D, 6'h3F);
        cyc("ori.iexec", S_IEXEC, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("ori.iwb", S_IWB, 1'b1, 1'b0, 1'b0, 1'b1);
        fetch_decode("j", 6'h02, 6'h00);
        cyc("j.jump", S_JUMP, 1'b1, 1'b0, 1'b0, 1'b1);

        // remaining R-type functs
        rfuncts = '{6'h21, 6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        for (int i = 0; i < 6; i++)
            run_rtype($sformatf("rtype%0d", i), rfuncts[i]);

        // illegal opcode and illegal funct: pulse in DECODE, no retire
        fetch_decode("illop", 6'h3F, 6'h21);
        cyc("illop.back", S_FETCH, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("illop.decode2", S_DECODE, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("illop.back2", S_FETCH, 1'b1, 1'b0, 1'b0, 1'b0);
        Op = 6'h00; Funct = 6'h00;
        cyc("illfn.decode", S_DECODE, 1'b1, 1'b0, 1'b0, 1'b0);

        // sw with a memory wait
        Op = 6'h2B;
        cyc("sw.fetch", S_FETCH, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("sw.decode", S_DECODE, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("sw.memadr", S_MEMADR, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("sw.memwr0", S_MEMWR, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("sw.memwr1", S_MEMWR, 1'b1, 1'b0, 1'b0, 1'b1);

        // sw abandoned by reset in MEMWR
        fetch_decode("swr", 6'h2B, 6'h00);
        cyc("swr.memadr", S_MEMADR, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("swr.memwr_rst", S_MEMWR, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc("swr.after", S_FETCH, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        assert (InstrCount === 32'd0) else begin
            errors++;
            $error("FAIL swr_count: got %0d expected 0", InstrCount);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
